// File: rtl/sram_seq_pkg.sv
// Shared types and sizing for the SRAM read sequencer.
package sram_seq_pkg;
  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 64;
  localparam int MAX_WORDS = 1024;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, FIN} seq_state_t;

  typedef struct packed {
    logic [NUM_BANKS-1:0][DATA_W-1:0] data;
    logic                             last;
  } rd_beat_t;
endpackage

// File: rtl/sram_read_sequencer.sv
// Walks an address range over the 4-bank buffer, one outstanding read at a time,
// and hands each captured word set downstream as a valid/ready beat.
module sram_read_sequencer
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic [3:0]        bank_mask,
  output logic              ren,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        chip_select,
  input  logic [DATA_W-1:0] read_data0,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] read_data3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int              CNT_W     = $clog2(RD_LAT);
  localparam logic [ADDR_W:0] NW_ONE    = 'd1;
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 'd1;

  seq_state_t                       state_q, state_d;
  logic [ADDR_W-1:0]                base_q, base_d;
  logic [ADDR_W:0]                  num_q, num_d;
  logic [ADDR_W:0]                  idx_q, idx_d;
  logic [3:0]                       mask_q, mask_d;
  logic [CNT_W-1:0]                 lat_q, lat_d;
  logic [NUM_BANKS-1:0][DATA_W-1:0] hold_q, hold_d;
  logic [NUM_BANKS-1:0][DATA_W-1:0] rd_data;
  logic                             ren_q, ren_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [3:0]                       cs_q, cs_d;
  logic                             err_q, err_d;
  logic                             is_last;
  rd_beat_t                         beat;

  assign rd_data = {read_data3, read_data2, read_data1, read_data0};
  assign is_last = (idx_q == num_q - NW_ONE);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    lat_d   = lat_q;
    hold_d  = hold_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (start && !abort) begin
        if (num_words == '0 || num_words > WORDS_MAX || bank_mask == 4'b0) begin
          err_d = 1'b1;
        end else begin
          base_d  = base_addr;
          num_d   = num_words;
          mask_d  = bank_mask;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: if (lat_q == '0) begin
        // Unselected banks drive don't-care data; zero them so the feeder never sees it.
        for (int b = 0; b < NUM_BANKS; b++) hold_d[b] = mask_q[b] ? rd_data[b] : '0;
        state_d = HOLD;
      end else begin
        lat_d = lat_q - CNT_ONE;
      end
      HOLD: if (out_ready) begin
        if (is_last) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + NW_ONE;
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;

    // Command outputs are registered, so they are set up on the edge entering ISSUE.
    ren_d  = (state_d == ISSUE);
    cs_d   = ren_d ? mask_d : 4'b0;
    addr_d = ren_d ? base_d + idx_d[ADDR_W-1:0] : addr_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      lat_q   <= '0;
      hold_q  <= '0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      cs_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      lat_q   <= lat_d;
      hold_q  <= hold_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
    end
  end

  assign beat.data = hold_q;
  assign beat.last = (state_q == HOLD) && is_last;

  assign ren         = ren_q;
  assign wen         = 1'b0;
  assign addr        = addr_q;
  assign chip_select = cs_q;
  assign out_valid   = (state_q == HOLD);
  assign out_last    = beat.last;
  assign out_data0   = beat.data[0];
  assign out_data1   = beat.data[1];
  assign out_data2   = beat.data[2];
  assign out_data3   = beat.data[3];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FIN);
  assign err         = err_q;
endmodule

// File: tb/tb_sram_read_sequencer.sv
// Bench for sram_read_sequencer: behavioural buffer model, event logs and per-scenario checks.
module tb_sram_read_sequencer;
  localparam int RD_LAT   = 6;
  localparam int BEAT_CYC = RD_LAT + 2;

  logic        clk = 1'b0;
  logic        n_rst, start, abort, out_ready;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic [3:0]  bank_mask;
  logic        ren, wen;
  logic [9:0]  addr;
  logic [3:0]  chip_select;
  logic [63:0] read_data0, read_data1, read_data2, read_data3;
  logic [63:0] out_data0, out_data1, out_data2, out_data3;
  logic        out_valid, out_last, busy, done, err;
  logic [255:0] out_bus;
  int checks = 0;
  int errors = 0;

  sram_read_sequencer #(.ADDR_W(10), .DATA_W(64), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words), .bank_mask(bank_mask),
    .ren(ren), .wen(wen), .addr(addr), .chip_select(chip_select),
    .read_data0(read_data0), .read_data1(read_data1),
    .read_data2(read_data2), .read_data3(read_data3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3),
    .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  assign out_bus = {out_data3, out_data2, out_data1, out_data0};

  // Buffer model: data appears 4 edges after the strobe, junk before that.
  logic [63:0] mem [4][1024];
  logic [63:0] rdata [4];
  logic [9:0]  pend_addr;
  int          pend_cnt = 0;
  assign read_data0 = rdata[0];
  assign read_data1 = rdata[1];
  assign read_data2 = rdata[2];
  assign read_data3 = rdata[3];

  always @(posedge clk) begin
    if (ren) begin
      pend_addr <= addr;
      pend_cnt  <= 3;
      for (int b = 0; b < 4; b++) rdata[b] <= {$urandom, $urandom};
    end else if (pend_cnt > 1) begin
      pend_cnt <= pend_cnt - 1;
      for (int b = 0; b < 4; b++) rdata[b] <= {$urandom, $urandom};
    end else if (pend_cnt == 1) begin
      pend_cnt <= 0;
      for (int b = 0; b < 4; b++) rdata[b] <= mem[b][pend_addr];
    end
  end

  // Event logs sampled mid-cycle.
  int           cyc = 0;
  int           ren_cyc[$];
  logic [9:0]   ren_addr[$];
  logic [3:0]   ren_cs[$];
  int           acc_cyc[$];
  logic [255:0] acc_data[$];
  logic         acc_last[$];
  int           vrise_cyc[$];
  int           done_cyc[$];
  int           err_cyc[$];
  int           busy_cnt = 0, stall_bad = 0, wen_hi = 0;
  logic         pv = 1'b0, pstall = 1'b0;
  logic [255:0] pdata = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ren) begin
      ren_cyc.push_back(cyc); ren_addr.push_back(addr); ren_cs.push_back(chip_select);
    end
    if (out_valid && !pv) vrise_cyc.push_back(cyc);
    if (out_valid && out_ready) begin
      acc_cyc.push_back(cyc); acc_data.push_back(out_bus); acc_last.push_back(out_last);
    end
    if (out_valid && pv && pstall && out_bus != pdata) stall_bad <= stall_bad + 1;
    if (done) done_cyc.push_back(cyc);
    if (err) err_cyc.push_back(cyc);
    if (busy) busy_cnt <= busy_cnt + 1;
    if (wen) wen_hi <= wen_hi + 1;
    pv     <= out_valid;
    pstall <= out_valid && !out_ready;
    pdata  <= out_bus;
  end

  function automatic logic [255:0] exp_beat(input int base, input int i, input logic [3:0] m);
    logic [255:0] r;
    int a;
    r = '0;
    a = (base + i) % 1024;
    for (int b = 0; b < 4; b++) if (m[b]) r[b*64 +: 64] = mem[b][a];
    return r;
  endfunction

  task automatic do_xfer(input logic [9:0] b, input logic [10:0] n, input logic [3:0] m,
                         input bit rnd_ready, input int stall_beat, input int stall_len,
                         output bit timeout);
    int acc0, d0, st;
    acc0 = acc_cyc.size(); d0 = done_cyc.size(); st = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n; bank_mask = m;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 10'($urandom); num_words = 11'($urandom); bank_mask = 4'($urandom);
    timeout = 1'b1;
    for (int c = 0; c < int'(n) * 40 + 60; c++) begin
      if (out_valid && (acc_cyc.size() - acc0) == stall_beat && st < stall_len) begin
        out_ready = 1'b0; st++;
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk); #1;
      if (done_cyc.size() > d0) begin timeout = 1'b0; break; end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = '0; num_words = '0; bank_mask = '0;
    repeat (3) @(posedge clk); #1;
    checks++; if ({ren, wen, out_valid, out_last, busy, done, err} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0", {ren, wen, out_valid, out_last, busy, done, err}); end
    checks++; if ({addr, chip_select} !== 14'b0) begin
      errors++; $display("FAIL reset_cmd got %h want 0", {addr, chip_select}); end
    checks++; if (out_bus !== 256'b0) begin
      errors++; $display("FAIL reset_data got %h want 0", out_bus); end
    n_rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if ({ren, out_valid, busy, done, err} !== 5'b0) begin
      errors++; $display("FAIL post_reset_idle got %b want 0", {ren, out_valid, busy, done, err}); end
  endtask

  task automatic test_single_beat();
    int r0, a0, v0, d0;
    bit to;
    logic [255:0] got;
    r0 = ren_cyc.size(); a0 = acc_cyc.size(); v0 = vrise_cyc.size(); d0 = done_cyc.size();
    mem[0][5] = 64'hDEAD_BEEF_0000_0005;
    do_xfer(10'd5, 11'd1, 4'b0001, 1'b0, -1, 0, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout got timeout want done"); end
    checks++; if (ren_cyc.size() - r0 != 1) begin
      errors++; $display("FAIL single_ren_count got %0d want 1", ren_cyc.size() - r0); end
    checks++; if (ren_addr[r0] !== 10'd5 || ren_cs[r0] !== 4'b0001) begin
      errors++; $display("FAIL single_cmd got addr %0d cs %b want 5 0001", ren_addr[r0], ren_cs[r0]); end
    checks++; if (vrise_cyc[v0] - ren_cyc[r0] != RD_LAT + 1) begin
      errors++; $display("FAIL single_latency got %0d want %0d", vrise_cyc[v0] - ren_cyc[r0], RD_LAT + 1); end
    got = acc_data[a0];
    checks++; if (got[63:0] !== 64'hDEAD_BEEF_0000_0005) begin
      errors++; $display("FAIL single_data0 got %h want deadbeef00000005", got[63:0]); end
    checks++; if (got[255:64] !== 192'b0) begin
      errors++; $display("FAIL single_unmasked got %h want 0", got[255:64]); end
    checks++; if (acc_last[a0] !== 1'b1) begin
      errors++; $display("FAIL single_last got %b want 1", acc_last[a0]); end
    checks++; if (done_cyc[d0] - acc_cyc[a0] != 1) begin
      errors++; $display("FAIL single_done got %0d want 1", done_cyc[d0] - acc_cyc[a0]); end
  endtask

  task automatic test_burst_backpressure();
    int r0, a0, v0, d0, s0;
    bit to;
    r0 = ren_cyc.size(); a0 = acc_cyc.size(); v0 = vrise_cyc.size(); d0 = done_cyc.size(); s0 = stall_bad;
    do_xfer(10'd0, 11'd4, 4'hF, 1'b0, 2, 3, to);
    checks++; if (to || ren_cyc.size() - r0 != 4 || acc_cyc.size() - a0 != 4) begin
      errors++; $display("FAIL burst_counts got ren %0d beats %0d to %b want 4 4 0",
                         ren_cyc.size() - r0, acc_cyc.size() - a0, to); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ren_addr[r0+k] !== 10'(k)) begin
        errors++; $display("FAIL burst_addr%0d got %0d want %0d", k, ren_addr[r0+k], k); end
      checks++; if (acc_data[a0+k] !== exp_beat(0, k, 4'hF)) begin
        errors++; $display("FAIL burst_data%0d got %h want %h", k, acc_data[a0+k], exp_beat(0, k, 4'hF)); end
      checks++; if (acc_last[a0+k] !== (k == 3)) begin
        errors++; $display("FAIL burst_last%0d got %b want %b", k, acc_last[a0+k], k == 3); end
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (ren_cyc[r0+k+1] != acc_cyc[a0+k] + 1) begin
        errors++; $display("FAIL burst_ren_after_acc%0d got %0d want %0d", k, ren_cyc[r0+k+1], acc_cyc[a0+k] + 1); end
    end
    checks++; if (acc_cyc[a0+2] - vrise_cyc[v0+2] != 3) begin
      errors++; $display("FAIL burst_stall_len got %0d want 3", acc_cyc[a0+2] - vrise_cyc[v0+2]); end
    checks++; if (stall_bad != s0) begin
      errors++; $display("FAIL burst_stable got %0d changes want 0", stall_bad - s0); end
    checks++; if (done_cyc.size() - d0 != 1) begin
      errors++; $display("FAIL burst_done got %0d want 1", done_cyc.size() - d0); end
  endtask

  task automatic test_wrap();
    int r0, a0;
    bit to;
    r0 = ren_cyc.size(); a0 = acc_cyc.size();
    do_xfer(10'd1022, 11'd4, 4'b1010, 1'b0, -1, 0, to);
    checks++; if (to || ren_cyc.size() - r0 != 4) begin
      errors++; $display("FAIL wrap_count got %0d to %b want 4 0", ren_cyc.size() - r0, to); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (ren_addr[r0+k] !== 10'((1022 + k) % 1024) || ren_cs[r0+k] !== 4'b1010) begin
        errors++; $display("FAIL wrap_addr%0d got %0d cs %b want %0d 1010", k, ren_addr[r0+k], ren_cs[r0+k], (1022 + k) % 1024); end
      checks++; if (acc_data[a0+k] !== exp_beat(1022, k, 4'b1010) || acc_last[a0+k] !== (k == 3)) begin
        errors++; $display("FAIL wrap_beat%0d got %h last %b want %h %b", k, acc_data[a0+k], acc_last[a0+k],
                           exp_beat(1022, k, 4'b1010), k == 3); end
    end
  endtask

  task automatic test_max_len();
    int r0, a0, d0, bad_addr, bad_data, bad_last, base;
    bit to;
    r0 = ren_cyc.size(); a0 = acc_cyc.size(); d0 = done_cyc.size();
    bad_addr = 0; bad_data = 0; bad_last = 0;
    base = $urandom_range(1, 1023);
    do_xfer(10'(base), 11'd1024, 4'hF, 1'b0, -1, 0, to);
    checks++; if (to || ren_cyc.size() - r0 != 1024 || acc_cyc.size() - a0 != 1024) begin
      errors++; $display("FAIL max_counts got ren %0d beats %0d to %b want 1024 1024 0",
                         ren_cyc.size() - r0, acc_cyc.size() - a0, to); end
    for (int k = 0; k < 1024; k++) begin
      if (ren_addr[r0+k] !== 10'((base + k) % 1024)) bad_addr++;
      if (acc_data[a0+k] !== exp_beat(base, k, 4'hF)) bad_data++;
      if (acc_last[a0+k] !== (k == 1023)) bad_last++;
    end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL max_addr got %0d bad want 0", bad_addr); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL max_data got %0d bad want 0", bad_data); end
    checks++; if (bad_last != 0) begin errors++; $display("FAIL max_last got %0d bad want 0", bad_last); end
    checks++; if (acc_cyc[a0+1023] - acc_cyc[a0] != 1023 * BEAT_CYC) begin
      errors++; $display("FAIL max_throughput got %0d want %0d", acc_cyc[a0+1023] - acc_cyc[a0], 1023 * BEAT_CYC); end
    checks++; if (done_cyc.size() - d0 != 1) begin
      errors++; $display("FAIL max_done got %0d want 1", done_cyc.size() - d0); end
  endtask

  task automatic test_random();
    int r0, a0, s0, base, n;
    logic [3:0] m;
    bit to;
    for (int t = 0; t < 6; t++) begin
      r0 = ren_cyc.size(); a0 = acc_cyc.size(); s0 = stall_bad;
      base = $urandom_range(0, 1023); n = $urandom_range(1, 24); m = 4'($urandom_range(1, 15));
      do_xfer(10'(base), 11'(n), m, 1'b1, -1, 0, to);
      checks++; if (to || ren_cyc.size() - r0 != n || acc_cyc.size() - a0 != n) begin
        errors++; $display("FAIL rand%0d_counts got ren %0d beats %0d to %b want %0d", t,
                           ren_cyc.size() - r0, acc_cyc.size() - a0, to, n); end
      for (int k = 0; k < n; k++) begin
        checks++; if (ren_addr[r0+k] !== 10'((base + k) % 1024) || ren_cs[r0+k] !== m) begin
          errors++; $display("FAIL rand%0d_cmd%0d got %0d %b want %0d %b", t, k, ren_addr[r0+k], ren_cs[r0+k],
                             (base + k) % 1024, m); end
        checks++; if (acc_data[a0+k] !== exp_beat(base, k, m) || acc_last[a0+k] !== (k == n - 1)) begin
          errors++; $display("FAIL rand%0d_beat%0d got %h %b want %h %b", t, k, acc_data[a0+k], acc_last[a0+k],
                             exp_beat(base, k, m), k == n - 1); end
        if (k > 0) begin
          checks++; if (ren_cyc[r0+k] != acc_cyc[a0+k-1] + 1) begin
            errors++; $display("FAIL rand%0d_order%0d got %0d want %0d", t, k, ren_cyc[r0+k], acc_cyc[a0+k-1] + 1); end
        end
      end
      checks++; if (stall_bad != s0) begin
        errors++; $display("FAIL rand%0d_stable got %0d want 0", t, stall_bad - s0); end
    end
  endtask

  task automatic test_illegal();
    int e0, r0, b0, d0;
    e0 = err_cyc.size(); r0 = ren_cyc.size(); b0 = busy_cnt;
    @(posedge clk); #1; start = 1'b1; base_addr = 10'd3; num_words = 11'd0; bank_mask = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (err_cyc.size() - e0 != 1 || busy_cnt != b0) begin
      errors++; $display("FAIL illegal_zero got err %0d busy %0d want 1 0", err_cyc.size() - e0, busy_cnt - b0); end
    start = 1'b1; num_words = 11'd3; bank_mask = 4'h0;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (err_cyc.size() - e0 != 2 || ren_cyc.size() != r0) begin
      errors++; $display("FAIL illegal_mask got err %0d ren %0d want 2 0", err_cyc.size() - e0, ren_cyc.size() - r0); end
    start = 1'b1; num_words = 11'd1025; bank_mask = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (err_cyc.size() - e0 != 3 || busy_cnt != b0) begin
      errors++; $display("FAIL illegal_1025 got err %0d busy %0d want 3 0", err_cyc.size() - e0, busy_cnt - b0); end
    start = 1'b1; abort = 1'b1; num_words = 11'd2;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (err_cyc.size() - e0 != 3 || busy_cnt != b0 || ren_cyc.size() != r0) begin
      errors++; $display("FAIL abort_beats_start got err %0d busy %0d ren %0d want 3 0 0",
                         err_cyc.size() - e0, busy_cnt - b0, ren_cyc.size() - r0); end
    d0 = done_cyc.size();
    start = 1'b1; num_words = 11'd1; bank_mask = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    start = 1'b1; num_words = 11'd0;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 40 && done_cyc.size() == d0; c++) begin @(posedge clk); #1; end
    repeat (2) @(posedge clk); #1;
    checks++; if (err_cyc.size() - e0 != 3 || ren_cyc.size() - r0 != 1 || done_cyc.size() - d0 != 1) begin
      errors++; $display("FAIL start_while_busy got err %0d ren %0d done %0d want 3 1 1",
                         err_cyc.size() - e0, ren_cyc.size() - r0, done_cyc.size() - d0); end
  endtask

  task automatic test_abort();
    int r0, a0, d0, base;
    logic [3:0] m;
    bit to;
    r0 = ren_cyc.size(); a0 = acc_cyc.size(); d0 = done_cyc.size();
    out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b1; base_addr = 10'd100; num_words = 11'd5; bank_mask = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 60 && (ren_cyc.size() - r0) < 2; c++) begin @(posedge clk); #1; end
    checks++; if (ren_cyc.size() - r0 != 2) begin
      errors++; $display("FAIL abort_reach got %0d ren want 2", ren_cyc.size() - r0); end
    repeat (2) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    checks++; if ({out_valid, busy, ren} !== 3'b0) begin
      errors++; $display("FAIL abort_idle got v/b/r %b want 000", {out_valid, busy, ren}); end
    repeat (15) @(posedge clk); #1;
    checks++; if (done_cyc.size() != d0 || ren_cyc.size() - r0 != 2 || acc_cyc.size() - a0 != 1) begin
      errors++; $display("FAIL abort_quiet got done %0d ren %0d beats %0d want 0 2 1",
                         done_cyc.size() - d0, ren_cyc.size() - r0, acc_cyc.size() - a0); end
    r0 = ren_cyc.size(); a0 = acc_cyc.size();
    base = $urandom_range(0, 1023); m = 4'($urandom_range(1, 15));
    do_xfer(10'(base), 11'd2, m, 1'b0, -1, 0, to);
    for (int k = 0; k < 2; k++) begin
      checks++; if (to || ren_addr[r0+k] !== 10'((base + k) % 1024) || acc_data[a0+k] !== exp_beat(base, k, m)) begin
        errors++; $display("FAIL abort_restart%0d got %0d %h want %0d %h", k, ren_addr[r0+k], acc_data[a0+k],
                           (base + k) % 1024, exp_beat(base, k, m)); end
    end
  endtask

  task automatic test_reset_mid_hold();
    int a0;
    bit to;
    out_ready = 1'b0;
    @(posedge clk); #1; start = 1'b1; base_addr = 10'd40; num_words = 11'd3; bank_mask = 4'hF;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 30 && !out_valid; c++) begin @(posedge clk); #1; end
    checks++; if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rst_hold_reach got %b want 1", out_valid); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if ({out_valid, ren, busy, done, out_last} !== 5'b0 || out_bus !== 256'b0) begin
      errors++; $display("FAIL rst_async got %b data %h want 0", {out_valid, ren, busy, done, out_last}, out_bus); end
    @(posedge clk); #1; n_rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if ({out_valid, ren, busy} !== 3'b0) begin
      errors++; $display("FAIL rst_release got %b want 000", {out_valid, ren, busy}); end
    out_ready = 1'b1;
    a0 = acc_cyc.size();
    do_xfer(10'd7, 11'd1, 4'b0100, 1'b0, -1, 0, to);
    checks++; if (to || acc_data[a0] !== exp_beat(7, 0, 4'b0100)) begin
      errors++; $display("FAIL rst_restart got %h want %h", acc_data[a0], exp_beat(7, 0, 4'b0100)); end
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 1024; a++) mem[b][a] = {$urandom, $urandom};
    test_reset();
    test_single_beat();
    test_burst_backpressure();
    test_wrap();
    test_illegal();
    test_abort();
    test_random();
    test_max_len();
    test_reset_mid_hold();
    checks++; if (wen_hi != 0) begin
      errors++; $display("FAIL wen_const got %0d high cycles want 0", wen_hi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
